pwm_to_servo: RTL and testbench
===============================

Name: pwm_to_servo

Overview:
- Dual-channel PWM pulse-width decoder, the receive-side counterpart of the servo-command PWM generator.
- Measures the high time of PWM_L/PWM_R and converts it back to 11-bit servo command units, using the same scale as the generator: 1 unit = CLKS_PER_UNIT clk cycles.
- Used to read back or loop-test motor PWM and to ingest external PWM command sources.
- Also flags a lost signal per channel.

Parameters:
- CLKS_PER_UNIT, 1000: clk cycles per servo unit; servo value = floor(high_cycles / CLKS_PER_UNIT).
- MAX_UNITS, 2047: saturation value of the decoded width; must be <= 2047.
- TIMEOUT_CYCLES, 3000000: clk cycles without a rising edge before a channel is declared lost (3 frames of 1000000).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- PWM_L  in  1  asynchronous PWM input, left channel.
- PWM_R  in  1  asynchronous PWM input, right channel.
- servo_L  out  11  last decoded left width, in units.
- servo_R  out  11  last decoded right width, in units.
- valid_L  out  1  one-cycle strobe when servo_L updates.
- valid_R  out  1  one-cycle strobe when servo_R updates.
- lost_L  out  1  left channel timed out.
- lost_R  out  1  right channel timed out.

Behaviour:
- Channels are fully independent identical instances of the logic below. "Edge N" means the Nth rising clk edge.
- Reset:
  - rst=0 sampled at a clk edge clears all state.
  - Outputs after reset: servo_*=0, valid_*=0, lost_*=0; FSM in ARM; counters cleared.
  - Reset mid-pulse discards the partial measurement; no valid is produced for it.
- Input conditioning:
  - 2-flop synchronizer, then a third register for edge detect.
  - rise = s2 & ~s3; fall = ~s2 & s3.
- FSM states:
  - ARM: wait for s2==0, then go to IDLE. A pulse already high at reset exit is never measured.
  - IDLE: on rise, clear prescaler and unit counter, go to HIGH.
  - HIGH: each cycle s2==1, the prescaler increments. When it reaches CLKS_PER_UNIT-1 it wraps to 0 and the unit counter increments, saturating at MAX_UNITS.
  - HIGH, on fall: servo_* <= unit counter; valid_* <= 1 for the next cycle only; lost_* <= 0; go to IDLE.
- Width arithmetic:
  - The cycle count includes the cycle on which rise is detected and excludes the cycle on which fall is detected, so an N-cycle input pulse counts N cycles.
  - The remainder is truncated.
  - A pulse shorter than CLKS_PER_UNIT decodes to 0 and still strobes valid.
- Latency: an input falling before edge k gives servo_*/valid_* updated at edge k+3. Valid is high for exactly one cycle.
- Timeout:
  - A cycle counter is cleared on every rise and increments otherwise, saturating.
  - On reaching TIMEOUT_CYCLES: lost_* <= 1 and servo_* <= 0 (safe stop); valid is not strobed; FSM returns to ARM.
  - The counter is stuck-high safe: a constant-high input also times out.
  - lost clears only on the next valid decode.
- Simultaneous events:
  - Timeout and fall on the same cycle: fall wins (decode, no lost).
  - L and R events never interact.
- Glitches: pulses shorter than 2 cycles may be missed; no debounce beyond the synchronizer.

Test Plan:
- Reset then PWM_L high for 500000 cycles, low for 500000 cycles -> valid_L pulses once 3 cycles after the fall, servo_L=500; lost_L=0; R outputs unchanged at 0.
- PWM_R pulse of 1999 cycles, then 1000 cycles, then 999 cycles -> servo_R = 1, then 1, then 0, each with a one-cycle valid_R.
- CLKS_PER_UNIT=1, PWM_L high 3000 cycles -> servo_L saturates to 2047 with valid_L.
- PWM_L held high across reset release, falling 100 cycles later -> no valid_L; the next full 20000-cycle pulse decodes to 20.
- After a decode of 300, PWM_L held low for 3000000 cycles -> lost_L=1, servo_L=0, no valid. A following 400000-cycle pulse -> servo_L=400, lost_L=0.
- rst=0 asserted mid-pulse on both channels -> all outputs 0 on the next cycle; the remainder of that pulse produces no valid.

Source files
------------

// File: rtl/pwm_to_servo.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_to_servo
//  Brief    : Dual-channel PWM high-time decoder to 11-bit servo units with
//             per-channel loss-of-signal detection.
//  Revision : 1.0
// ============================================================================
module pwm_to_servo #(
    parameter int CLKS_PER_UNIT  = 1000,
    parameter int MAX_UNITS      = 2047,
    parameter int TIMEOUT_CYCLES = 3000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PWM_L,
    input  logic        PWM_R,
    output logic [10:0] servo_L,
    output logic [10:0] servo_R,
    output logic        valid_L,
    output logic        valid_R,
    output logic        lost_L,
    output logic        lost_R
);

    localparam int c_PRE_W = (CLKS_PER_UNIT > 1) ? $clog2(CLKS_PER_UNIT) : 1;
    localparam int c_TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_PRE_W-1:0] c_PRE_LAST  = c_PRE_W'(CLKS_PER_UNIT - 1);
    localparam logic [10:0]        c_UNITS_MAX = 11'(MAX_UNITS);
    localparam logic [c_TO_W-1:0]  c_TO_HIT    = c_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TO_W-1:0]  c_TO_SAT    = c_TO_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] c_ARM  = 2'd0;
    localparam logic [1:0] c_IDLE = 2'd1;
    localparam logic [1:0] c_HIGH = 2'd2;

    logic [1:0]  w_pwm;
    logic [10:0] w_servo [2];
    logic [1:0]  w_valid;
    logic [1:0]  w_lost;

    assign w_pwm = {PWM_R, PWM_L};

    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic               r_s1, r_s2, r_s3;
        logic [1:0]         r_state;
        logic [c_PRE_W-1:0] r_pre;
        logic [10:0]        r_units;
        logic [c_TO_W-1:0]  r_to_cnt;
        logic               r_evt_dec, r_evt_to;
        logic [10:0]        r_evt_units;
        logic [10:0]        r_servo;
        logic               r_valid, r_lost;

        logic               w_rise, w_fall, w_dec, w_to_hit, w_wrap;
        logic [c_PRE_W-1:0] w_pre_base, w_pre_inc;
        logic [10:0]        w_units_base, w_units_inc;

        assign w_rise   = r_s2 & ~r_s3;
        assign w_fall   = ~r_s2 & r_s3;
        assign w_dec    = (r_state == c_HIGH) && w_fall;
        assign w_to_hit = ~w_rise && (r_to_cnt == c_TO_HIT);

        // A new measurement starts from zero and already counts the rise cycle.
        assign w_pre_base   = (r_state == c_IDLE) ? '0 : r_pre;
        assign w_units_base = (r_state == c_IDLE) ? '0 : r_units;
        assign w_wrap       = (w_pre_base == c_PRE_LAST);
        assign w_pre_inc    = w_wrap ? '0 : w_pre_base + c_PRE_W'(1);
        assign w_units_inc  = (w_wrap && (w_units_base != c_UNITS_MAX)) ?
                              w_units_base + 11'd1 : w_units_base;

        always_ff @(posedge clk) begin
            if (!rst) begin
                // Synchronizer resets high so a pulse in progress at reset exit
                // looks like a steady high: no false rise, ARM waits for low.
                r_s1        <= 1'b1;
                r_s2        <= 1'b1;
                r_s3        <= 1'b1;
                r_state     <= c_ARM;
                r_pre       <= '0;
                r_units     <= '0;
                r_to_cnt    <= '0;
                r_evt_dec   <= 1'b0;
                r_evt_to    <= 1'b0;
                r_evt_units <= '0;
            end else begin
                r_s1 <= w_pwm[g];
                r_s2 <= r_s1;
                r_s3 <= r_s2;

                if (w_rise) begin
                    r_to_cnt <= '0;
                end else if (r_to_cnt != c_TO_SAT) begin
                    r_to_cnt <= r_to_cnt + c_TO_W'(1);
                end

                r_evt_dec <= 1'b0;
                r_evt_to  <= 1'b0;

                if (w_dec) begin
                    r_evt_dec   <= 1'b1;
                    r_evt_units <= r_units;
                    r_state     <= c_IDLE;
                end else if (w_to_hit) begin
                    r_evt_to <= 1'b1;
                    r_state  <= c_ARM;
                end else begin
                    case (r_state)
                        c_ARM: begin
                            if (!r_s2) r_state <= c_IDLE;
                        end
                        c_IDLE: begin
                            if (w_rise) begin
                                r_pre   <= w_pre_inc;
                                r_units <= w_units_inc;
                                r_state <= c_HIGH;
                            end
                        end
                        c_HIGH: begin
                            if (r_s2) begin
                                r_pre   <= w_pre_inc;
                                r_units <= w_units_inc;
                            end
                        end
                        default: r_state <= c_ARM;
                    endcase
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                r_servo <= '0;
                r_valid <= 1'b0;
                r_lost  <= 1'b0;
            end else if (r_evt_dec) begin
                r_servo <= r_evt_units;
                r_valid <= 1'b1;
                r_lost  <= 1'b0;
            end else if (r_evt_to) begin
                r_servo <= '0;
                r_valid <= 1'b0;
                r_lost  <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end

        assign w_servo[g] = r_servo;
        assign w_valid[g] = r_valid;
        assign w_lost[g]  = r_lost;
    end

    assign servo_L = w_servo[0];
    assign servo_R = w_servo[1];
    assign valid_L = w_valid[0];
    assign valid_R = w_valid[1];
    assign lost_L  = w_lost[0];
    assign lost_R  = w_lost[1];

endmodule
`default_nettype wire

// File: tb/tb_pwm_to_servo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_to_servo
//  Brief    : Directed plus randomized bench for pwm_to_servo against an
//             edge-time reference model.
//  Revision : 1.0
// ============================================================================
module tb_pwm_to_servo;

    localparam int C_UNIT = 4;
    localparam int C_MAX  = 50;
    localparam int C_TO   = 800;

    logic        clk = 1'b0;
    logic        rst;
    logic        PWM_L, PWM_R;
    logic [10:0] servo_L, servo_R;
    logic        valid_L, valid_R, lost_L, lost_R;

    int checks = 0;
    int errors = 0;
    int vcnt [2] = '{0, 0};

    pwm_to_servo #(
        .CLKS_PER_UNIT (C_UNIT),
        .MAX_UNITS     (C_MAX),
        .TIMEOUT_CYCLES(C_TO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .PWM_L  (PWM_L),
        .PWM_R  (PWM_R),
        .servo_L(servo_L),
        .servo_R(servo_R),
        .valid_L(valid_L),
        .valid_R(valid_R),
        .lost_L (lost_L),
        .lost_R (lost_R)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: all timing is measured in clock-edge indices. A sample
    // taken at edge n is acted on at edge n+2 and visible on outputs at n+3.
    bit hist  [2][4];
    bit arm   [2];
    bit meas  [2];
    bit fired [2];
    int start [2];
    int last  [2];
    int cur_servo [2], nxt_servo [2];
    bit cur_valid [2], nxt_valid [2];
    bit cur_lost  [2], nxt_lost  [2];

    initial begin : compare
        int cyc;
        bit started;
        bit smp [2];
        cyc = 0;
        started = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            smp[0] = PWM_L;
            smp[1] = PWM_R;
            if (valid_L === 1'b1) vcnt[0]++;
            if (valid_R === 1'b1) vcnt[1]++;
            if (rst === 1'b0) begin
                started = 1'b1;
                for (int ch = 0; ch < 2; ch++) begin
                    for (int k = 0; k < 4; k++) hist[ch][k] = 1'b1;
                    arm[ch] = 1'b1; meas[ch] = 1'b0; fired[ch] = 1'b0;
                    last[ch] = cyc; start[ch] = cyc;
                    cur_servo[ch] = 0; cur_valid[ch] = 1'b0; cur_lost[ch] = 1'b0;
                    nxt_servo[ch] = 0; nxt_valid[ch] = 1'b0; nxt_lost[ch] = 1'b0;
                end
                chk("reset_servo_L", int'(servo_L), 0);
                chk("reset_servo_R", int'(servo_R), 0);
                chk("reset_valid",   int'({valid_R, valid_L}), 0);
                chk("reset_lost",    int'({lost_R, lost_L}), 0);
            end else if (started) begin
                for (int ch = 0; ch < 2; ch++) begin
                    bit a, b, rise, fall, hit;
                    int w;
                    cur_servo[ch] = nxt_servo[ch];
                    cur_valid[ch] = nxt_valid[ch];
                    cur_lost[ch]  = nxt_lost[ch];
                    if (ch == 0) begin
                        chk("servo_L", int'(servo_L), cur_servo[0]);
                        chk("valid_L", int'(valid_L), int'(cur_valid[0]));
                        chk("lost_L",  int'(lost_L),  int'(cur_lost[0]));
                    end else begin
                        chk("servo_R", int'(servo_R), cur_servo[1]);
                        chk("valid_R", int'(valid_R), int'(cur_valid[1]));
                        chk("lost_R",  int'(lost_R),  int'(cur_lost[1]));
                    end
                    for (int k = 3; k > 0; k--) hist[ch][k] = hist[ch][k-1];
                    hist[ch][0] = smp[ch];
                    a    = hist[ch][2];
                    b    = hist[ch][3];
                    rise = a & ~b;
                    fall = ~a & b;
                    hit  = !fired[ch] && (cyc - last[ch] == C_TO) && !rise;
                    if (hit) fired[ch] = 1'b1;
                    nxt_servo[ch] = cur_servo[ch];
                    nxt_valid[ch] = 1'b0;
                    nxt_lost[ch]  = cur_lost[ch];
                    if (fall && meas[ch]) begin
                        w = (cyc - start[ch]) / C_UNIT;
                        nxt_servo[ch] = (w > C_MAX) ? C_MAX : w;
                        nxt_valid[ch] = 1'b1;
                        nxt_lost[ch]  = 1'b0;
                        meas[ch] = 1'b0;
                    end else if (hit) begin
                        nxt_servo[ch] = 0;
                        nxt_lost[ch]  = 1'b1;
                        arm[ch]  = 1'b1;
                        meas[ch] = 1'b0;
                    end else if (arm[ch]) begin
                        if (!a) arm[ch] = 1'b0;
                    end else if (!meas[ch] && rise) begin
                        meas[ch]  = 1'b1;
                        start[ch] = cyc;
                    end
                    if (rise) begin
                        last[ch]  = cyc;
                        fired[ch] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic pulse_l(input int hi, input int lo);
        PWM_L = 1'b1;
        repeat (hi) @(negedge clk);
        PWM_L = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic pulse_r(input int hi, input int lo);
        PWM_R = 1'b1;
        repeat (hi) @(negedge clk);
        PWM_R = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin : stimulus
        int v0, v1;
        rst = 1'b0; PWM_L = 1'b0; PWM_R = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 120 cycles high -> 30 units; right channel untouched
        v0 = vcnt[0];
        pulse_l(120, 20);
        chk("t1_servo_L", int'(servo_L), 30);
        chk("t1_valid_L_count", vcnt[0] - v0, 1);
        chk("t1_lost_L", int'(lost_L), 0);
        chk("t1_servo_R", int'(servo_R), 0);
        chk("t1_valid_R_count", vcnt[1], 0);

        // 7, 4, 3 cycles -> 1, 1, 0 units
        v1 = vcnt[1];
        pulse_r(7, 10);
        chk("t2a_servo_R", int'(servo_R), 1);
        pulse_r(4, 10);
        chk("t2b_servo_R", int'(servo_R), 1);
        pulse_r(3, 10);
        chk("t2c_servo_R", int'(servo_R), 0);
        chk("t2_valid_R_count", vcnt[1] - v1, 3);

        // saturation: 300 cycles = 75 units, clipped to 50
        pulse_l(300, 10);
        chk("t3_servo_L_sat", int'(servo_L), C_MAX);

        // pulse already high at reset release is ignored
        PWM_L = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        v0 = vcnt[0];
        repeat (100) @(negedge clk);
        PWM_L = 1'b0;
        repeat (20) @(negedge clk);
        chk("t4_no_valid_L", vcnt[0] - v0, 0);
        chk("t4_servo_L", int'(servo_L), 0);
        pulse_l(80, 10);
        chk("t4_next_servo_L", int'(servo_L), 20);
        chk("t4_next_valid_L", vcnt[0] - v0, 1);

        // timeout after a decode of 15, then recovery
        pulse_l(60, 10);
        chk("t5_servo_L", int'(servo_L), 15);
        v0 = vcnt[0];
        repeat (890) @(negedge clk);
        chk("t5_lost_L", int'(lost_L), 1);
        chk("t5_safe_servo_L", int'(servo_L), 0);
        chk("t5_timeout_no_valid", vcnt[0] - v0, 0);
        pulse_l(40, 10);
        chk("t5_recover_servo_L", int'(servo_L), 10);
        chk("t5_recover_lost_L", int'(lost_L), 0);

        // reset mid-pulse on both channels
        PWM_L = 1'b1; PWM_R = 1'b1;
        repeat (30) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        v0 = vcnt[0]; v1 = vcnt[1];
        repeat (30) @(negedge clk);
        PWM_L = 1'b0; PWM_R = 1'b0;
        repeat (20) @(negedge clk);
        chk("t6_no_valid_L", vcnt[0] - v0, 0);
        chk("t6_no_valid_R", vcnt[1] - v1, 0);
        chk("t6_servo_L", int'(servo_L), 0);
        chk("t6_servo_R", int'(servo_R), 0);

        // randomized independent traffic, including glitches and timeouts
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    int hi, lo;
                    hi = ($urandom_range(7, 0) == 0) ? 850 : $urandom_range(250, 1);
                    lo = ($urandom_range(7, 0) == 0) ? 900 : $urandom_range(300, 1);
                    pulse_l(hi, lo);
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    int hi, lo;
                    hi = ($urandom_range(7, 0) == 0) ? 850 : $urandom_range(250, 1);
                    lo = ($urandom_range(7, 0) == 0) ? 900 : $urandom_range(300, 1);
                    pulse_r(hi, lo);
                end
            end
        join

        repeat (20) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
